// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// The fetch/decode environment takes the master view; the queue takes the slave view.
interface instr_fetch_queue_if #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [PC_W-1:0] out_pc;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// DEPTH-entry FIFO of {instruction, PC} pairs between fetch and decode.
// A synchronous flush drops wrong-path entries on redirect.
module instr_fetch_queue #(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_flush,
   instr_fetch_queue_if.slave         bus,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [XLEN-1:0]  r_instr [DEPTH];
   logic [PC_W-1:0]  r_pc    [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   // Ready/valid depend only on the occupancy register, so out_ready never reaches in_ready.
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = bus.in_valid & ~w_full;
   assign w_pop   = bus.out_ready & ~w_empty;

   assign bus.in_ready  = ~w_full;
   assign bus.out_valid = ~w_empty;
   assign bus.out_instr = w_empty ? '0 : r_instr[r_rd_ptr];
   assign bus.out_pc    = w_empty ? '0 : r_pc[r_rd_ptr];
   assign o_count       = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_instr[i] <= '0;
            r_pc[i]    <= '0;
         end
      end else if (i_flush) begin
         // Storage is left as-is; count=0 masks the stale entries.
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_instr[r_wr_ptr] <= bus.in_instr;
            r_pc[r_wr_ptr]    <= bus.in_pc;
            r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)
            r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed plus randomized bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;
   localparam int XLEN  = 32;
   localparam int PC_W  = 32;
   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic [2:0] count;

   int n_checks;
   int n_pass;
   ent_t mq[$];

   instr_fetch_queue_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

   instr_fetch_queue #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .bus     (bus),
      .o_count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(mq.size()));
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
      chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mq.size() < DEPTH));
      chk({tag, ".out_instr"}, bus.out_instr, (mq.size() != 0) ? mq[0].instr : 32'h0);
      chk({tag, ".out_pc"}, bus.out_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
   endtask

   // One clock: drive inputs, advance model by the queue rules, compare after the edge.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, input string tag, output logic pushed);
      logic do_push, do_pop;
      ent_t e;
      bus.in_valid  = v;
      bus.in_instr  = ins;
      bus.in_pc     = pc;
      bus.out_ready = rdy;
      flush         = fl;
      do_push = v && (mq.size() < DEPTH);
      do_pop  = rdy && (mq.size() != 0);
      @(posedge clk);
      #1;
      if (fl) begin
         mq.delete();
         pushed = 1'b0;
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            e.instr = ins;
            e.pc    = pc;
            mq.push_back(e);
         end
         pushed = do_push;
      end
      chk_model(tag);
   endtask

   initial begin
      logic        p;
      logic [31:0] nxt_pc;
      logic [31:0] exp_pc;
      logic [31:0] fill_instr [4];
      n_checks = 0;
      n_pass   = 0;
      fill_instr[0] = 32'h00000013;
      fill_instr[1] = 32'h00500093;
      fill_instr[2] = 32'h00A00113;
      fill_instr[3] = 32'h002081B3;

      // Reset held with in_valid asserted
      rst_n = 1'b0;
      flush = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'hDEADBEEF;
      bus.in_pc     = 32'h100;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_model("reset");
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;

      // Fill to full, then a refused fifth push
      for (int i = 0; i < 4; i++)
         cycle(1'b1, fill_instr[i], 32'(i * 4), 1'b0, 1'b0, "fill", p);
      chk("full.count", 32'(count), 32'd4);
      chk("full.in_ready", 32'(bus.in_ready), 32'd0);
      cycle(1'b1, 32'h11111111, 32'h10, 1'b0, 1'b0, "fifth_refused", p);
      chk("fifth.pushed", 32'(p), 32'd0);
      chk("fifth.head_pc", bus.out_pc, 32'h0);
      chk("fifth.head_instr", bus.out_instr, 32'h00000013);

      // Drain with continuing pushes across pointer wrap; pops must be in PC order
      nxt_pc = 32'h10;
      exp_pc = 32'h0;
      for (int i = 0; i < 14; i++) begin
         if (mq.size() != 0) begin
            chk("drain.order", bus.out_pc, exp_pc);
            exp_pc += 32'h4;
         end
         cycle(1'b1, nxt_pc ^ 32'hA5A50000, nxt_pc, 1'b1, 1'b0, "drain", p);
         if (p) nxt_pc += 32'h4;
      end

      // Simultaneous push/pop at count=2
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "flush_pre", p);
      cycle(1'b1, 32'h0000AAA1, 32'h200, 1'b0, 1'b0, "pp_fill", p);
      cycle(1'b1, 32'h0000AAA2, 32'h204, 1'b0, 1'b0, "pp_fill", p);
      cycle(1'b1, 32'h0000AAA3, 32'h208, 1'b1, 1'b0, "pushpop", p);
      chk("pushpop.count", 32'(count), 32'd2);
      chk("pushpop.head_pc", bus.out_pc, 32'h204);

      // Flush at count=3 with a concurrent push of PC 0x20
      cycle(1'b1, 32'h0000AAA4, 32'h20C, 1'b0, 1'b0, "to3", p);
      chk("to3.count", 32'(count), 32'd3);
      cycle(1'b1, 32'h00000020, 32'h20, 1'b0, 1'b1, "flush", p);
      chk("flush.count", 32'(count), 32'd0);
      chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
      cycle(1'b1, 32'h00000040, 32'h40, 1'b0, 1'b0, "post_flush", p);
      chk("post_flush.head_pc", bus.out_pc, 32'h40);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "post_flush_pop", p);

      // Asynchronous reset between edges at count=2
      cycle(1'b1, 32'h0000B001, 32'h300, 1'b0, 1'b0, "ar_fill", p);
      cycle(1'b1, 32'h0000B002, 32'h304, 1'b0, 1'b0, "ar_fill", p);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      mq.delete();
      chk("async_rst.out_valid", 32'(bus.out_valid), 32'd0);
      chk("async_rst.count", 32'(count), 32'd0);
      chk("async_rst.out_pc", bus.out_pc, 32'h0);
      #1;
      rst_n = 1'b1;
      cycle(1'b1, 32'h0000C001, 32'h400, 1'b0, 1'b0, "after_rst", p);
      chk("after_rst.head_pc", bus.out_pc, 32'h400);
      chk("after_rst.head_instr", bus.out_instr, 32'h0000C001);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(0, 9) < 7), $urandom, $urandom, ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 15) == 0), "rand", p);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
